// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : D-stage hazard unit for the pipelined MIPS core. Keeps a shadow
//             pipeline of {dst, tnew} pairs that advances in lock-step with
//             the datapath. From it the unit derives the stall signal and the
//             nearest-producer forwarding selects. A busy counter tracks the
//             multi-cycle multiply/divide unit.
//  Ports    :
//    clk, reset                 clock, asynchronous active-high reset
//    D_rs, D_rt                 source registers of the D instruction
//    D_rs_tuse, D_rt_tuse       Tuse per operand (all ones = operand unused)
//    D_dst, D_tnew              destination (0 = none) and Tnew as seen in E
//    D_md_start, D_md_div       D starts mult/div (D_md_div=1 selects divide)
//    D_md_use                   D is any HI/LO or MDU instruction
//    stall                      freeze PC/F/D and bubble E (combinational)
//    fwd_rs, fwd_rt             0 = register file, k = stage k-1 produces
//    md_busy                    MDU counter non-zero
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NUM_STAGES  = 3,
  parameter int REG_AW      = 5,
  parameter int TW          = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [REG_AW-1:0]                 D_rs,
  input  logic [REG_AW-1:0]                 D_rt,
  input  logic [TW-1:0]                     D_rs_tuse,
  input  logic [TW-1:0]                     D_rt_tuse,
  input  logic [REG_AW-1:0]                 D_dst,
  input  logic [TW-1:0]                     D_tnew,
  input  logic                              D_md_start,
  input  logic                              D_md_div,
  input  logic                              D_md_use,
  output logic                              stall,
  output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_rs,
  output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_rt,
  output logic                              md_busy
);

  localparam int SW = $clog2(NUM_STAGES + 1);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [REG_AW-1:0] dst_q  [NUM_STAGES];
  logic [REG_AW-1:0] dst_d  [NUM_STAGES];
  logic [TW-1:0]     tnew_q [NUM_STAGES];
  logic [TW-1:0]     tnew_d [NUM_STAGES];

  logic              e_start_q, e_start_d;
  logic              e_div_q,   e_div_d;
  logic [CW-1:0]     cnt_q,     cnt_d;

  // --------------------------------------------------------------------------
  // Nearest-producer lookup. Scanning from the farthest stage toward E lets
  // the closest match overwrite any older one, so the youngest producer wins.
  // --------------------------------------------------------------------------
  logic          hit_rs, hit_rt;
  logic [SW-1:0] idx_rs, idx_rt;
  logic [TW-1:0] tnew_rs, tnew_rt;

  always_comb begin
    hit_rs  = 1'b0;
    idx_rs  = '0;
    tnew_rs = '0;
    hit_rt  = 1'b0;
    idx_rt  = '0;
    tnew_rt = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if ((D_rs != '0) && (dst_q[k] == D_rs)) begin
        hit_rs  = 1'b1;
        idx_rs  = SW'(k + 1);
        tnew_rs = tnew_q[k];
      end
      if ((D_rt != '0) && (dst_q[k] == D_rt)) begin
        hit_rt  = 1'b1;
        idx_rt  = SW'(k + 1);
        tnew_rt = tnew_q[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall and forwarding
  // --------------------------------------------------------------------------
  logic stall_rs, stall_rt, stall_md;

  // An unused operand carries the maximum Tuse, which can never be below a
  // TW-bit Tnew, so it needs no separate qualification.
  assign stall_rs = hit_rs && (D_rs_tuse < tnew_rs);
  assign stall_rt = hit_rt && (D_rt_tuse < tnew_rt);

  // The MDU is already committed while the start sits in E, before the
  // counter has been loaded, so E_start also blocks HI/LO users.
  assign md_busy  = (cnt_q != '0);
  assign stall_md = D_md_use && (md_busy || e_start_q);

  assign stall    = stall_rs || stall_rt || stall_md;
  assign fwd_rs   = idx_rs;
  assign fwd_rt   = idx_rt;

  // --------------------------------------------------------------------------
  // Shadow pipeline next state
  // --------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      dst_d[k]  = '0;
      tnew_d[k] = '0;
    end
    // A stalled D instruction stays put while a bubble enters E.
    if (!stall) begin
      dst_d[0]  = D_dst;
      tnew_d[0] = D_tnew;
    end
    for (int k = 1; k < NUM_STAGES; k++) begin
      dst_d[k]  = dst_q[k-1];
      tnew_d[k] = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - TW'(1)) : '0;
    end
  end

  // --------------------------------------------------------------------------
  // MDU tracker next state
  // --------------------------------------------------------------------------
  always_comb begin
    e_start_d = D_md_start && !stall;
    e_div_d   = D_md_div;
    cnt_d     = cnt_q;
    // A fresh start overrides any residual count.
    if (e_start_q) begin
      cnt_d = e_div_q ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        dst_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
      e_start_q <= 1'b0;
      e_div_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        dst_q[k]  <= dst_d[k];
        tnew_q[k] <= tnew_d[k];
      end
      e_start_q <= e_start_d;
      e_div_q   <= e_div_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined MIPS CPU, sitting beside the D stage. It replaces the purely combinational Tuse/Tnew comparator with an internal shadow pipeline of destination/Tnew pairs that runs in lock-step with the datapath. It also adds a multi-cycle multiply/divide busy tracker. Outputs are the D-stage stall and per-operand nearest-producer forwarding selects.

## Interface
Parameters:
- `NUM_STAGES`, 3: tracked stages after D (index 0=E, 1=M, 2=W, …); range 2..6.
- `REG_AW`, 5: register address width.
- `TW`, 3: Tuse/Tnew width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be ≥ `MULT_CYCLES`.

Ports (`SW` = clog2(NUM_STAGES+1), `CW` = clog2(DIV_CYCLES+1)). One clock; `reset` is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `D_rs`, `D_rt` in REG_AW: source registers of the D instruction.
- `D_rs_tuse`, `D_rt_tuse` in TW: Tuse per operand; 7 means unused.
- `D_dst` in REG_AW: write destination; 0 means none.
- `D_tnew` in TW: Tnew as seen when the instruction sits in E.
- `D_md_start` in 1: D instruction is mult/multu/div/divu.
- `D_md_div` in 1: qualifies `D_md_start`; 1 = divide.
- `D_md_use` in 1: D instruction is any HI/LO or MDU instruction (start, mfhi, mflo, mthi, mtlo).
- `stall` out 1: freezes PC/F/D and bubbles E (combinational).
- `fwd_rs`, `fwd_rt` out SW: 0 = register file, k = stage k-1 is the nearest producer.
- `md_busy` out 1: MDU counter non-zero.

## Operation
- Shadow pipeline: per stage, a `dst` field (REG_AW bits) and a `tnew` field (TW bits).
- Each clock edge:
  - Stage 0 loads {`D_dst`, `D_tnew`} when `stall`=0, or a bubble {0, 0} when `stall`=1.
  - Stage k≥1 loads stage k-1 with `tnew` saturating-decremented (0 stays 0).
- Nearest match for operand r: the lowest stage index with `dst`==r and r≠0. Farther stages are ignored.
- `stall_rs` = nearest match exists and `D_rs_tuse` < its `tnew`. `stall_rt` is the same rule for rt.
- `fwd_rs` = (nearest-match index + 1), or 0 if there is no match. It is produced independently of stall. `fwd_rt` follows the same rule.
- Register 0 never matches: `fwd` stays 0 and no stall results.
- MDU tracker:
  - Registered flag `E_start` is loaded with `D_md_start & ~stall`. `E_div` is loaded with `D_md_div`.
  - Counter `cnt` (CW bits): if `E_start`, load `E_div ? DIV_CYCLES : MULT_CYCLES`; else if `cnt`≠0, decrement.
  - `md_busy` = (`cnt`≠0).
  - `stall_md` = `D_md_use` & (`md_busy` | `E_start`).
- `stall` = `stall_rs` | `stall_rt` | `stall_md`.
- Simultaneous events:
  - `E_start`=1 while `cnt`≠0 cannot occur, because the start would have been stalled. If forced, the load wins.
  - A stalled start never reaches `E_start`.

## Timing
- Reset (asynchronous, immediate) clears all stage fields, `E_start`, `E_div` and `cnt`. In reset: `md_busy`=0, `fwd_rs`=`fwd_rt`=0 unless D inputs match (they cannot, because stages hold dst 0), and `stall`=0.
- Reset asserted mid-divide drops `md_busy` the same cycle and clears all pending stalls.
- `stall`, `fwd_*` and `md_busy` are combinational from the current inputs and state, valid before the next edge. There is zero added latency.
- MDU start enters E at cycle t:
  - `E_start`=1 during t.
  - `md_busy`=1 during t+1 .. t+N.
  - Any `D_md_use` instruction stalls through cycles t .. t+N and proceeds at t+N+1.
- A load-use stall lasts (Tnew − Tuse) cycles and is bounded by `NUM_STAGES`.

## Test plan
- Reset mid-divide: start div, assert `reset` at busy cycle 4 → `md_busy`, `stall` and `cnt` go to 0 immediately. After release, mflo in D → `stall`=0.
- Load-use: lw (`D_dst`=1, `D_tnew`=2), then addu with `D_rs`=1, `rs_tuse`=1:
  - `stall`=1 for exactly 1 cycle, and stage 0 then holds the bubble.
  - Next cycle: `stall`=0, `fwd_rs`=2.
- Branch after ALU: addu (`D_dst`=3, `D_tnew`=1), then beq `D_rt`=3, `rt_tuse`=0 → 1 stall cycle, then `fwd_rt`=2.
- Zero register: producer `dst`=0, `tnew`=2, and consumer `D_rs`=0 with `tuse`=0 → `stall`=0, `fwd_rs`=0.
- Divide then mflo: div enters E at t, mflo held in D → `stall`=1 for 11 cycles (t..t+10), released at t+11. With mult → 6 cycles.
- Priority: E and M both `dst`=5 with `tnew` 0, consumer `D_rs`=5 → `fwd_rs`=1. Then E `tnew`=1 with `tuse`=0 → `stall`=1, even though M's value is ready.
